// File: rtl/bcd_updown_cntr.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_updown_cntr
//  Description : Parametrised multi-digit BCD up/down counter with digit
//                chaining, parallel load, count enable, terminal-count flags,
//                registered carry/borrow pulses and a load-error pulse.
//                Each digit is a 4-bit BCD register; the carry/borrow chain
//                between digits is a purely combinational enable chain, so no
//                binary addition ever crosses a digit boundary.
//
//  Parameters  : DIGITS  number of BCD digits (1..8), COUNT width = 4*DIGITS
//
//  Ports       : CLK      in   clock, all state changes on posedge
//                R        in   synchronous active-high reset
//                EN       in   count enable (gates UP/DN only)
//                UP       in   increment request
//                DN       in   decrement request
//                LD       in   parallel load strobe
//                LD_VAL   in   load value, digit i at [4i+3:4i]
//                COUNT    out  registered BCD count
//                CARRY    out  registered pulse, up-wrap all-9s -> all-0s
//                BORROW   out  registered pulse, down-wrap all-0s -> all-9s
//                TC_MAX   out  combinational, all digits == 9
//                TC_ZERO  out  combinational, all digits == 0
//                LD_ERR   out  registered pulse, a loaded digit was > 9
//
//  Build macro : BCD_CNTR_SAT_EN  when defined the counter saturates at
//                all-9s / all-0s instead of wrapping, and CARRY/BORROW are
//                tied low.
//
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_updown_cntr #(
  parameter int DIGITS = 2
) (
  input  logic                CLK,
  input  logic                R,
  input  logic                EN,
  input  logic                UP,
  input  logic                DN,
  input  logic                LD,
  input  logic [4*DIGITS-1:0] LD_VAL,
  output logic [4*DIGITS-1:0] COUNT,
  output logic                CARRY,
  output logic                BORROW,
  output logic                TC_MAX,
  output logic                TC_ZERO,
  output logic                LD_ERR
);

  localparam int c_W = 4 * DIGITS;

  logic [c_W-1:0]    r_count;
  logic              r_ld_err;
  logic [c_W-1:0]    w_next_cnt;
  logic [c_W-1:0]    w_ld_clean;
  logic [DIGITS-1:0] w_ld_bad;
  logic [DIGITS-1:0] w_is9;
  logic [DIGITS-1:0] w_is0;
  // w_lo9[i] / w_lo0[i]: every digit below i is 9 / 0. Entry DIGITS covers
  // the whole count and doubles as the terminal-count flag.
  logic [DIGITS:0]   w_lo9;
  logic [DIGITS:0]   w_lo0;
  logic              w_inc_req;
  logic              w_dec_req;
  logic              w_step_inc;
  logic              w_step_dec;

  // UP and DN together cancel out.
  assign w_inc_req = EN & UP & ~DN;
  assign w_dec_req = EN & DN & ~UP;

`ifdef BCD_CNTR_SAT_EN
  // Saturating build: suppress the step that would wrap.
  assign w_step_inc = w_inc_req & ~w_lo9[DIGITS];
  assign w_step_dec = w_dec_req & ~w_lo0[DIGITS];
`else
  assign w_step_inc = w_inc_req;
  assign w_step_dec = w_dec_req;
`endif

  assign w_lo9[0] = 1'b1;
  assign w_lo0[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_d;
      logic [3:0] w_ld_d;

      assign w_d    = r_count[4*gi +: 4];
      assign w_ld_d = LD_VAL[4*gi +: 4];

      assign w_is9[gi]   = (w_d == 4'd9);
      assign w_is0[gi]   = (w_d == 4'd0);
      assign w_lo9[gi+1] = w_lo9[gi] & w_is9[gi];
      assign w_lo0[gi+1] = w_lo0[gi] & w_is0[gi];

      // Out-of-range load digits are replaced by 0 and flagged.
      assign w_ld_bad[gi]          = (w_ld_d > 4'd9);
      assign w_ld_clean[4*gi +: 4] = w_ld_bad[gi] ? 4'd0 : w_ld_d;

      // A digit moves only when every lower digit is at its rollover value.
      // Digits are always 0..9, so the 4-bit +/-1 never leaves BCD range.
      assign w_next_cnt[4*gi +: 4] =
        (w_step_inc & w_lo9[gi]) ? (w_is9[gi] ? 4'd0 : w_d + 4'd1) :
        (w_step_dec & w_lo0[gi]) ? (w_is0[gi] ? 4'd9 : w_d - 4'd1) :
                                   w_d;
    end
  endgenerate

`ifndef BCD_CNTR_SAT_EN
  logic r_carry;
  logic r_borrow;
`endif

  always_ff @(posedge CLK) begin
    if (R) begin
      r_count  <= '0;
      r_ld_err <= 1'b0;
`ifndef BCD_CNTR_SAT_EN
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
`endif
    end else if (LD) begin
      r_count  <= w_ld_clean;
      r_ld_err <= |w_ld_bad;
`ifndef BCD_CNTR_SAT_EN
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
`endif
    end else begin
      r_count  <= w_next_cnt;
      r_ld_err <= 1'b0;
`ifndef BCD_CNTR_SAT_EN
      r_carry  <= w_inc_req & w_lo9[DIGITS];
      r_borrow <= w_dec_req & w_lo0[DIGITS];
`endif
    end
  end

  assign COUNT   = r_count;
  assign LD_ERR  = r_ld_err;
  assign TC_MAX  = w_lo9[DIGITS];
  assign TC_ZERO = w_lo0[DIGITS];

`ifdef BCD_CNTR_SAT_EN
  assign CARRY  = 1'b0;
  assign BORROW = 1'b0;
`else
  assign CARRY  = r_carry;
  assign BORROW = r_borrow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_cntr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_updown_cntr
//  Description : Self-checking bench for bcd_updown_cntr. Two instances
//                (DIGITS=2 and DIGITS=4) are driven with directed vectors;
//                each vector pushes its hand-computed expected response into
//                a queue and an independent monitor compares it against the
//                DUT outputs on the following falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_updown_cntr;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DIGITS=2 instance
  logic       r2_r, r2_en, r2_up, r2_dn, r2_ld;
  logic [7:0] r2_ldv;
  logic [7:0] w2_cnt;
  logic       w2_carry, w2_borrow, w2_tmax, w2_tzero, w2_lderr;

  // DIGITS=4 instance
  logic        r4_r, r4_en, r4_up, r4_dn, r4_ld;
  logic [15:0] r4_ldv;
  logic [15:0] w4_cnt;
  logic        w4_carry, w4_borrow, w4_tmax, w4_tzero, w4_lderr;

  bcd_updown_cntr #(.DIGITS(2)) u_dut2 (
    .CLK(CLK), .R(r2_r), .EN(r2_en), .UP(r2_up), .DN(r2_dn), .LD(r2_ld),
    .LD_VAL(r2_ldv), .COUNT(w2_cnt), .CARRY(w2_carry), .BORROW(w2_borrow),
    .TC_MAX(w2_tmax), .TC_ZERO(w2_tzero), .LD_ERR(w2_lderr)
  );

  bcd_updown_cntr #(.DIGITS(4)) u_dut4 (
    .CLK(CLK), .R(r4_r), .EN(r4_en), .UP(r4_up), .DN(r4_dn), .LD(r4_ld),
    .LD_VAL(r4_ldv), .COUNT(w4_cnt), .CARRY(w4_carry), .BORROW(w4_borrow),
    .TC_MAX(w4_tmax), .TC_ZERO(w4_tzero), .LD_ERR(w4_lderr)
  );

  typedef struct {
    int          id;
    string       name;
    logic [15:0] cnt;
    logic        carry;
    logic        borrow;
    logic        lderr;
    logic        tmax;
    logic        tzero;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Saturating build swaps the wrap expectations.
`ifdef BCD_CNTR_SAT_EN
  localparam bit c_SAT = 1'b1;
`else
  localparam bit c_SAT = 1'b0;
`endif

  // Monitor: on every falling edge, compare all queued expectations.
  initial begin
    forever begin
      @(negedge CLK);
      while (q_exp.size() > 0) begin
        exp_t e;
        logic [15:0] a_cnt;
        logic a_c, a_b, a_l, a_mx, a_z;
        e = q_exp.pop_front();
        if (e.id == 2) begin
          a_cnt = {8'h00, w2_cnt};
          a_c = w2_carry; a_b = w2_borrow; a_l = w2_lderr;
          a_mx = w2_tmax; a_z = w2_tzero;
        end else begin
          a_cnt = w4_cnt;
          a_c = w4_carry; a_b = w4_borrow; a_l = w4_lderr;
          a_mx = w4_tmax; a_z = w4_tzero;
        end
        n_checks++;
        if (a_cnt !== e.cnt || a_c !== e.carry || a_b !== e.borrow ||
            a_l !== e.lderr || a_mx !== e.tmax || a_z !== e.tzero) begin
          n_errors++;
          $display("FAIL %s: got cnt=%h c=%b b=%b lerr=%b tmax=%b tzero=%b, want cnt=%h c=%b b=%b lerr=%b tmax=%b tzero=%b",
                   e.name, a_cnt, a_c, a_b, a_l, a_mx, a_z,
                   e.cnt, e.carry, e.borrow, e.lderr, e.tmax, e.tzero);
        end
      end
    end
  end

  // One clock edge on the 2-digit instance; called at a falling edge.
  task automatic step2(input string nm, input logic r, ld, en, up, dn,
                       input logic [7:0] ldv, input logic [7:0] ecnt,
                       input logic ec, eb, el);
    exp_t e;
    r2_r = r; r2_ld = ld; r2_en = en; r2_up = up; r2_dn = dn; r2_ldv = ldv;
    @(posedge CLK);
    e.id = 2; e.name = nm; e.cnt = {8'h00, ecnt};
    e.carry = ec; e.borrow = eb; e.lderr = el;
    e.tmax = (ecnt == 8'h99); e.tzero = (ecnt == 8'h00);
    q_exp.push_back(e);
    @(negedge CLK);
  endtask

  task automatic step4(input string nm, input logic r, ld, en, up, dn,
                       input logic [15:0] ldv, input logic [15:0] ecnt,
                       input logic ec, eb, el);
    exp_t e;
    r4_r = r; r4_ld = ld; r4_en = en; r4_up = up; r4_dn = dn; r4_ldv = ldv;
    @(posedge CLK);
    e.id = 4; e.name = nm; e.cnt = ecnt;
    e.carry = ec; e.borrow = eb; e.lderr = el;
    e.tmax = (ecnt == 16'h9999); e.tzero = (ecnt == 16'h0000);
    q_exp.push_back(e);
    @(negedge CLK);
  endtask

  // Expected BCD count after k increments from zero (k = 1..12).
  logic [7:0] c_up_tab [1:12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                  8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};

  initial begin
    r2_r = 1'b1; r2_ld = 1'b0; r2_en = 1'b0; r2_up = 1'b0; r2_dn = 1'b0; r2_ldv = '0;
    r4_r = 1'b1; r4_ld = 1'b0; r4_en = 1'b0; r4_up = 1'b0; r4_dn = 1'b0; r4_ldv = '0;
    @(negedge CLK);

    // 1. reset then 12 increments
    step2("reset2", 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    for (int k = 1; k <= 12; k++)
      step2($sformatf("up%0d", k), 0, 0, 1, 1, 0, 8'h00, c_up_tab[k], 0, 0, 0);

    // 2. up-wrap from 99
    step2("ld99", 0, 1, 0, 0, 0, 8'h99, 8'h99, 0, 0, 0);
    step2("wrap_up", 0, 0, 1, 1, 0, 8'h00, c_SAT ? 8'h99 : 8'h00, !c_SAT, 0, 0);
    step2("carry_clr", 0, 0, 0, 0, 0, 8'h00, c_SAT ? 8'h99 : 8'h00, 0, 0, 0);

    // 3. down-wrap from 00
    step2("ld00", 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    step2("wrap_dn", 0, 0, 1, 0, 1, 8'h00, c_SAT ? 8'h00 : 8'h99, 0, !c_SAT, 0);
    step2("borrow_clr", 0, 0, 0, 0, 0, 8'h00, c_SAT ? 8'h00 : 8'h99, 0, 0, 0);

    // 4. digit chaining and hold cases
    step2("ld39", 0, 1, 0, 0, 0, 8'h39, 8'h39, 0, 0, 0);
    step2("up39", 0, 0, 1, 1, 0, 8'h00, 8'h40, 0, 0, 0);
    step2("dn40", 0, 0, 1, 0, 1, 8'h00, 8'h39, 0, 0, 0);
    step2("updn_hold", 0, 0, 1, 1, 1, 8'h00, 8'h39, 0, 0, 0);
    step2("en0_hold", 0, 0, 0, 1, 0, 8'h00, 8'h39, 0, 0, 0);
    step2("ld10", 0, 1, 0, 0, 0, 8'h10, 8'h10, 0, 0, 0);
    step2("dn10", 0, 0, 1, 0, 1, 8'h00, 8'h09, 0, 0, 0);

    // 5. load error and load priority
    step2("ldA7", 0, 1, 0, 0, 0, 8'hA7, 8'h07, 0, 0, 1);
    step2("ld_over_up", 0, 1, 1, 1, 0, 8'h55, 8'h55, 0, 0, 0);
    step2("ld9B", 0, 1, 0, 0, 0, 8'h9B, 8'h90, 0, 0, 1);
    step2("lderr_clr", 0, 0, 0, 0, 0, 8'h00, 8'h90, 0, 0, 0);
    step2("ld99_wrap_ld", 0, 1, 0, 0, 0, 8'h99, 8'h99, 0, 0, 0);
    step2("ld_at_max_up", 0, 1, 1, 1, 0, 8'h99, 8'h99, 0, 0, 0);

    // 6. reset beats load and counting
    step2("rst_ld_up", 1, 1, 1, 1, 0, 8'h45, 8'h00, 0, 0, 0);
    step2("wrap_pre", 0, 1, 0, 0, 0, 8'h99, 8'h99, 0, 0, 0);
    step2("wrap_again", 0, 0, 1, 1, 0, 8'h00, c_SAT ? 8'h99 : 8'h00, !c_SAT, 0, 0);
    step2("rst_clr_pulse", 1, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);

    // 4-digit instance
    step4("reset4", 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step4("ld9999", 0, 1, 0, 0, 0, 16'h9999, 16'h9999, 0, 0, 0);
    step4("wrap4_up", 0, 0, 1, 1, 0, 16'h0000, c_SAT ? 16'h9999 : 16'h0000, !c_SAT, 0, 0);
    step4("ld1000", 0, 1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0);
    step4("dn1000", 0, 0, 1, 0, 1, 16'h0000, 16'h0999, 0, 0, 0);
    step4("up0999", 0, 0, 1, 1, 0, 16'h0000, 16'h1000, 0, 0, 0);
    step4("ld0000", 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step4("wrap4_dn", 0, 0, 1, 0, 1, 16'h0000, c_SAT ? 16'h0000 : 16'h9999, 0, !c_SAT, 0);
    step4("ld4_err", 0, 1, 0, 0, 0, 16'hF3C2, 16'h0302, 0, 0, 1);

    // drain the queue
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, want 0", q_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
